// File: rtl/inst_mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_resp_pkg
// Types and constants shared by the instruction-memory responder and its
// storage array.
//   state_e      : responder FSM states (idle / latency wait / response)
//   EBREAK_INST  : word returned for any faulting fetch
//   DEFAULT_BASE : byte address of word 0 (core reset PC)
//   CNT_W        : width of the latency counter (LATENCY range 0..7)
// -----------------------------------------------------------------------------
package inst_mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
  localparam logic [63:0] DEFAULT_BASE = 64'h0000_0000_8000_0000;
  localparam int          CNT_W        = 3;

endpackage

// File: rtl/inst_mem_resp_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// Instruction word storage: one synchronous write port and one registered
// read port. A read and a write to the same index on the same edge return
// the word held before the write. Contents are never reset.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_idx   : write word index
//   i_wr_data  : write word
//   i_rd_en    : read strobe; the read register only updates when set
//   i_rd_idx   : read word index
//   o_rd_data  : registered read word
// -----------------------------------------------------------------------------
module inst_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_mem_resp.sv
// -----------------------------------------------------------------------------
// inst_mem_resp
// Single-outstanding instruction fetch responder with a programmable response
// latency. A request is accepted in IDLE, waits LATENCY cycles, then the word
// (or an ebreak with an error flag for misaligned / out-of-range addresses)
// is presented until the core takes it.
// Ports:
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   : fetch request handshake
//   i_req_addr                  : fetch byte address
//   o_resp_valid / i_resp_ready : response handshake
//   o_resp_inst, o_resp_err     : fetched word and fault flag
//   i_load_en, i_load_idx,
//   i_load_data                 : preload write port (usable in any state)
// -----------------------------------------------------------------------------
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter logic [63:0] BASE    = DEFAULT_BASE,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [63:0]              i_req_addr,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [31:0]              o_resp_inst,
  output logic                     o_resp_err,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_idx,
  input  logic [31:0]              i_load_data
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter preload on acceptance; unused when LATENCY is zero.
  localparam logic [CNT_W-1:0] CNT_INIT =
      (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [63:0]      r_addr;
  logic             r_err;

  logic             w_accept;
  logic             w_enter_resp;
  logic [63:0]      w_fetch_addr;
  logic [63:0]      w_index;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_fetch_err;
  logic [31:0]      w_rd_data;

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

  // With zero latency the RESP-entry edge is the accepting edge, so the
  // address comes straight from the port; otherwise from the captured copy.
  assign w_fetch_addr   = (r_state == ST_IDLE) ? i_req_addr : r_addr;
  assign w_index        = (w_fetch_addr - BASE) >> 2;
  assign w_misaligned   = (w_fetch_addr[1:0] != 2'b00);
  // Below-BASE addresses wrap to a huge index, but test them explicitly so
  // the intent does not depend on the wrap.
  assign w_out_of_range = (w_fetch_addr < BASE) || (w_index >= 64'(DEPTH));
  assign w_fetch_err    = w_misaligned || w_out_of_range;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (LATENCY == 0) begin
            w_state_next = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (i_resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr <= i_req_addr;
      end
      if (w_enter_resp) begin
        r_err <= w_fetch_err;
      end
    end
  end

  // The array read register is only loaded on the RESP-entry edge, so it
  // holds the fetched word stable for the whole response phase.
  inst_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .i_clk     (i_clk),
    .i_wr_en   (i_load_en),
    .i_wr_idx  (i_load_idx),
    .i_wr_data (i_load_data),
    .i_rd_en   (w_enter_resp),
    .i_rd_idx  (w_index[IDX_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign o_req_ready  = (r_state == ST_IDLE) && i_rst_n;
  assign o_resp_valid = (r_state == ST_RESP);
  assign o_resp_err   = o_resp_valid && r_err;
  assign o_resp_inst  = !o_resp_valid ? 32'h0 :
                        r_err         ? EBREAK_INST : w_rd_data;

endmodule

// File: tb/tb_inst_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_resp
// Two responders (LATENCY 2 and 0) driven by directed and random fetches,
// checked against a word-array model and the address rules.
// -----------------------------------------------------------------------------
module tb_inst_mem_resp;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic              clk = 1'b0;
  logic [1:0]        rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][63:0]  req_addr;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [1:0][31:0]  resp_inst;
  logic [1:0]        resp_err;
  logic [1:0]        load_en;
  logic [1:0][9:0]   load_idx;
  logic [1:0][31:0]  load_data;

  logic [31:0] model_mem [2][DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      inst_mem_resp #(
        .BASE    (BASE),
        .DEPTH   (DEPTH),
        .LATENCY ((gi == 0) ? 2 : 0)
      ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n[gi]),
        .i_req_valid  (req_valid[gi]),
        .o_req_ready  (req_ready[gi]),
        .i_req_addr   (req_addr[gi]),
        .o_resp_valid (resp_valid[gi]),
        .i_resp_ready (resp_ready[gi]),
        .o_resp_inst  (resp_inst[gi]),
        .o_resp_err   (resp_err[gi]),
        .i_load_en    (load_en[gi]),
        .i_load_idx   (load_idx[gi]),
        .i_load_data  (load_data[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected response straight from the address rules.
  task automatic model_resp(input int d, input logic [63:0] a,
                            output logic [31:0] inst, output logic err);
    logic [63:0] idx;
    if (a[1:0] != 2'b00 || a < BASE) begin
      inst = EBREAK; err = 1'b1;
    end else begin
      idx = (a - BASE) / 4;
      if (idx >= 64'(DEPTH)) begin
        inst = EBREAK; err = 1'b1;
      end else begin
        inst = model_mem[d][int'(idx)]; err = 1'b0;
      end
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic load(input int d, input int idx, input logic [31:0] data);
    load_en[d] = 1'b1; load_idx[d] = 10'(idx); load_data[d] = data;
    @(posedge clk);
    model_mem[d][idx] = data;
    @(negedge clk);
    load_en[d] = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [63:0] addr, input int hold,
                       input bit coload, input logic [9:0] cl_idx,
                       input logic [31:0] cl_data);
    logic [31:0] ei;
    logic        ee;
    int          lat;
    lat = lat_of(d);
    model_resp(d, addr, ei, ee);
    check("idle_ready", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    if (coload && lat == 0) begin
      load_en[d] = 1'b1; load_idx[d] = cl_idx; load_data[d] = cl_data;
    end
    @(posedge clk);
    if (coload && lat == 0) model_mem[d][int'(cl_idx)] = cl_data;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      load_en[d]   = 1'b0;
      // Requests outside IDLE must be ignored and the address not re-sampled.
      req_valid[d] = 1'($urandom_range(0, 1));
      req_addr[d]  = {$urandom, $urandom};
      if (c <= lat) begin
        check("wait_valid", 64'(resp_valid[d]), 64'd0);
        check("wait_ready", 64'(req_ready[d]), 64'd0);
        if (coload && c == lat) begin
          load_en[d] = 1'b1; load_idx[d] = cl_idx; load_data[d] = cl_data;
        end
        @(posedge clk);
        if (coload && c == lat) model_mem[d][int'(cl_idx)] = cl_data;
      end else begin
        check("resp_valid", 64'(resp_valid[d]), 64'd1);
        check("resp_inst", 64'(resp_inst[d]), 64'(ei));
        check("resp_err", 64'(resp_err[d]), 64'(ee));
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(resp_valid[d]), 64'd1);
      check("hold_inst", 64'(resp_inst[d]), 64'(ei));
      check("hold_err", 64'(resp_err[d]), 64'(ee));
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    check("post_valid", 64'(resp_valid[d]), 64'd0);
    check("post_ready", 64'(req_ready[d]), 64'd1);
    $display("txn dut=%0d addr=%h exp_inst=%h exp_err=%0d hold=%0d coload=%0d",
             d, addr, ei, ee, hold, coload);
  endtask

  task automatic reset_mid(input int d);
    req_valid[d] = 1'b1;
    req_addr[d]  = BASE + 64'd8;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("busy_ready", 64'(req_ready[d]), 64'd0);
    rst_n[d] = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready[d]), 64'd0);
    check("rst_valid", 64'(resp_valid[d]), 64'd0);
    check("rst_inst", 64'(resp_inst[d]), 64'd0);
    check("rst_err", 64'(resp_err[d]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
    #1;
    check("rel_ready", 64'(req_ready[d]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rel_no_resp", 64'(resp_valid[d]), 64'd0);
      check("rel_ready_hold", 64'(req_ready[d]), 64'd1);
    end
    $display("txn dut=%0d reset during pending fetch", d);
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1, 2: return BASE + 64'(4 * $urandom_range(0, 63));
      3:       return BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      4:       return BASE - 64'(4 * $urandom_range(1, 16));
      5:       return BASE + 64'(4 * (DEPTH + $urandom_range(0, 100)));
      default: return BASE + 64'(4 * (DEPTH - 1));
    endcase
  endfunction

  initial begin
    rst_n      = 2'b00;
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = '0;
    load_en    = '0;
    load_idx   = '0;
    load_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 64'(req_ready[d]), 64'd0);
      check("reset_valid", 64'(resp_valid[d]), 64'd0);
      check("reset_inst", 64'(resp_inst[d]), 64'd0);
      check("reset_err", 64'(resp_err[d]), 64'd0);
    end
    rst_n = 2'b11;
    #1;
    for (int d = 0; d < 2; d++) check("release_ready", 64'(req_ready[d]), 64'd1);
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) load(d, i, $urandom);
      load(d, DEPTH - 1, $urandom);
    end

    // Basic fetches, faults and boundaries.
    load(0, 0, 32'h0000_0413);
    fetch(0, 64'h8000_0000, 0, 1'b0, '0, '0);
    load(1, 1, 32'h0010_0093);
    fetch(1, 64'h8000_0004, 4, 1'b0, '0, '0);
    for (int d = 0; d < 2; d++) begin
      fetch(d, 64'h8000_0002, 1, 1'b0, '0, '0);
      fetch(d, 64'h7FFF_FFFC, 0, 1'b0, '0, '0);
      fetch(d, 64'h8000_1000, 0, 1'b0, '0, '0);
      fetch(d, 64'h8000_0FFC, 0, 1'b0, '0, '0);
      fetch(d, 64'h0000_0000, 0, 1'b0, '0, '0);
    end

    // Load colliding with the RESP-entry read, then refetch.
    for (int d = 0; d < 2; d++) begin
      load(d, 3, 32'h1111_1111);
      fetch(d, 64'h8000_000C, 1, 1'b1, 10'd3, 32'hDEAD_BEEF);
      fetch(d, 64'h8000_000C, 0, 1'b0, '0, '0);
    end

    // Reset mid-WAIT (latency 2) and mid-RESP (latency 0).
    for (int d = 0; d < 2; d++) begin
      reset_mid(d);
      fetch(d, 64'h8000_0010, 0, 1'b0, '0, '0);
    end

    // Random mix of loads and fetches.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 9) < 3) begin
          load(d, $urandom_range(0, 63), $urandom);
        end else begin
          fetch(d, rand_addr(), $urandom_range(0, 3),
                1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 63)), $urandom);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter BASE, 64'h80000000, byte address of word 0 (core reset PC).
REQ-002 Parameter DEPTH, 1024, number of 32-bit instruction words.
REQ-003 Parameter LATENCY, 2, wait cycles between request acceptance and response (0..7).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_addr  in  64  fetch byte address (core PC).
REQ-009 resp_valid  out  1  instruction response present.
REQ-010 resp_ready  in  1  core accepts the response.
REQ-011 resp_inst  out  32  fetched instruction word.
REQ-012 resp_err  out  1  misaligned or out-of-range fetch.
REQ-013 load_en  in  1  preload write strobe.
REQ-014 load_idx  in  log2(DEPTH)  preload word index.
REQ-015 load_data  in  32  preload word.

Function
REQ-016 States: IDLE, WAIT, RESP; one outstanding request, no pipelining.
REQ-017 IDLE: req_ready=1; req_valid=1 at an edge captures req_addr, goes to WAIT with counter=LATENCY-1, or directly to RESP when LATENCY=0.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; at counter=0 goes to RESP on the next edge.
REQ-019 resp_valid is first high exactly LATENCY+1 cycles after the accepting edge.
REQ-020 RESP: resp_valid=1; resp_inst/resp_err stable until resp_ready=1 at an edge, then IDLE.
REQ-021 No request is accepted in the same cycle as a response handshake; the next acceptance is possible one cycle after the response handshake.
REQ-022 Word index = (addr-BASE)>>2, computed in 64-bit unsigned arithmetic.
REQ-023 addr[1:0]!=0: resp_err=1, resp_inst=32'h00100073 (ebreak).
REQ-024 addr<BASE or index>=DEPTH: resp_err=1, resp_inst=32'h00100073.
REQ-025 Otherwise resp_err=0, resp_inst=mem[index].
REQ-026 Array is read on the edge entering RESP and latched into resp_inst.
REQ-027 load_en writes mem[load_idx]=load_data at the edge, in any state.
REQ-028 A load to the pending index on the same edge as the RESP entry returns the old word; earlier loads are visible.
REQ-029 req_valid outside IDLE is ignored; req_addr is not re-sampled.

Reset
REQ-030 rst=0 asynchronously forces IDLE, counter=0, resp_valid=0, resp_inst=0, resp_err=0, req_ready=1 (while rst=0, req_ready=0).
REQ-031 Reset mid-WAIT or mid-RESP discards the pending request with no response.
REQ-032 Array contents are not reset.

Structure
REQ-033 Shared package holds the state enum, the EBREAK_INST constant (32'h00100073) and the default BASE.
REQ-034 The storage is one sub-module, inst_mem_array (sync write port, registered read port).
REQ-035 FSM, latency counter and address checks stay in inst_mem_resp.

Verification
REQ-036 Preload mem[0]=32'h00000413, LATENCY=2, request 0x80000000 -> resp_valid on the 3rd edge after acceptance, inst=0x00000413, err=0.
REQ-037 LATENCY=0, request 0x80000004 with mem[1]=0x00100093 -> resp_valid the cycle after acceptance; resp_ready held 0 for 4 cycles -> outputs unchanged.
REQ-038 Request 0x80000002 -> err=1, inst=0x00100073; request 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> err=1.
REQ-039 Reset pulse during WAIT -> resp_valid never asserts, req_ready=1 after release, next request served normally.
REQ-040 load_en to mem[3]=0xDEADBEEF on the RESP-entry edge of a fetch of 0x8000000C (old 0x11111111) -> returns 0x11111111; refetch returns 0xDEADBEEF.
